// File: rtl/sha256_pkg.sv
// SHA-256 constants, state encoding and round/schedule helper functions
// shared by the chunk engine and its message schedule.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule as a 16-word sliding window; w_out is the word
// consumed by the current round.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block_in,
    output logic [31:0]  w_out
);

    logic [31:0] w [0:15];
    logic [31:0] w_new;

    assign w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    assign w_out = w[0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
        end else if (load) begin
            for (int unsigned i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
        end else if (shift) begin
            for (int unsigned i = 0; i < 15; i++) w[i] <= w[i + 1];
            w[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha256_chunk_engine.sv
// Iterative SHA-256 compression: one round per clock, 64 rounds plus a
// final-add cycle per 512-bit chunk, chaining H across multi-chunk messages.
module sha256_chunk_engine
    import sha256_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         chunk_valid,
    output logic         chunk_ready,
    input  logic [511:0] chunk,
    input  logic         first,
    input  logic         last,
    output logic         busy,
    output logic [255:0] hash,
    output logic         hash_valid
);

    state_t      state, state_nxt;
    logic        accept, do_round, do_final;
    logic [5:0]  rnd;
    logic        last_r;
    logic [31:0] hreg  [0:7];
    logic [31:0] v     [0:7];
    logic [31:0] h_sum [0:7];
    logic [31:0] w_t, t1, t2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        do_round    = 1'b0;
        do_final    = 1'b0;
        chunk_ready = 1'b0;
        unique case (state)
            IDLE: begin
                chunk_ready = 1'b1;
                if (chunk_valid) begin
                    accept    = 1'b1;
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                do_round = 1'b1;
                if (rnd == 6'd63) state_nxt = FINAL;
            end
            FINAL: begin
                do_final  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = ~chunk_ready;

    sha256_msg_schedule u_sched (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .shift    (do_round),
        .block_in (chunk),
        .w_out    (w_t)
    );

    // v[0..7] hold working variables a..h
    assign t1 = v[7] + bsig1(v[4]) + ch(v[4], v[5], v[6]) + K[rnd] + w_t;
    assign t2 = bsig0(v[0]) + maj(v[0], v[1], v[2]);

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) h_sum[i] = hreg[i] + v[i];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rnd        <= '0;
            last_r     <= 1'b0;
            hash       <= '0;
            hash_valid <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                hreg[i] <= IV[i];
                v[i]    <= '0;
            end
        end else begin
            hash_valid <= 1'b0;
            if (accept) begin
                last_r <= last;
                for (int unsigned i = 0; i < 8; i++) begin
                    v[i] <= first ? IV[i] : hreg[i];
                    if (first) hreg[i] <= IV[i];
                end
            end
            if (do_round) begin
                rnd  <= rnd + 6'd1;
                v[0] <= t1 + t2;
                v[1] <= v[0];
                v[2] <= v[1];
                v[3] <= v[2];
                v[4] <= v[3] + t1;
                v[5] <= v[4];
                v[6] <= v[5];
                v[7] <= v[6];
            end
            if (do_final) begin
                for (int unsigned i = 0; i < 8; i++) hreg[i] <= h_sum[i];
                if (last_r) begin
                    for (int unsigned i = 0; i < 8; i++) hash[255 - 32*i -: 32] <= h_sum[i];
                    hash_valid <= 1'b1;
                end
            end
        end
    end

endmodule
